// File: rtl/axon_sched_pkg.sv
// Shared types and default sizing for the axon spike scheduler.
package axon_sched_pkg;

    localparam int N_AXONS_DEF = 16;
    localparam int AXON_W_DEF  = 4;
    localparam int DLY_W_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        START    = 2'd2,
        CAPTURE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sched_slot_mem.sv
// Circular per-tick spike schedule: N_SLOTS x N_AXONS bits with a bit-set port,
// a whole-slot clear port and one asynchronous slot read.
module sched_slot_mem
    import axon_sched_pkg::*;
#(
    parameter int N_AXONS = N_AXONS_DEF,
    parameter int AXON_W  = AXON_W_DEF,
    parameter int DLY_W   = DLY_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en,
    input  logic [DLY_W-1:0]   set_slot,
    input  logic [AXON_W-1:0]  set_axon,
    input  logic               clr_en,
    input  logic [DLY_W-1:0]   clr_slot,
    input  logic [DLY_W-1:0]   rd_slot,
    output logic [N_AXONS-1:0] rd_data
);

    localparam int N_SLOTS = 2 ** DLY_W;

    logic [N_AXONS-1:0] slots [N_SLOTS];

    // A set into the slot being cleared in the same cycle survives the clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                slots[i] <= '0;
            end
        end else begin
            if (clr_en) begin
                slots[clr_slot] <= '0;
            end
            if (set_en) begin
                slots[set_slot][set_axon] <= 1'b1;
            end
        end
    end

    assign rd_data = slots[rd_slot];

endmodule

// File: rtl/axon_spike_scheduler.sv
// Buffers delayed spike packets and hands the due slot to the core controller on each tick.
// Optional macro SCHED_PENDING_TICK_EN adds a one-deep pending-tick flag.
module axon_spike_scheduler
    import axon_sched_pkg::*;
#(
    parameter int N_AXONS = N_AXONS_DEF,
    parameter int AXON_W  = AXON_W_DEF,
    parameter int DLY_W   = DLY_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               pkt_valid,
    output logic               pkt_ready,
    input  logic [AXON_W-1:0]  pkt_axon,
    input  logic [DLY_W-1:0]   pkt_delay,
    input  logic               ctrl_ready,
    output logic               ctrl_start,
    input  logic               ctrl_spike_buffer_wen,
    output logic [N_AXONS-1:0] spike_vec,
    output logic               tick_miss
);

    sched_state_t       state;
    logic [DLY_W-1:0]   rd_ptr;
    logic [DLY_W-1:0]   rd_slot;
    logic [N_AXONS-1:0] rd_data;
    logic [N_AXONS-1:0] bypass;
    logic               accept;
    logic               capture_done;
    logic               tick_go;
    logic               reload;
    logic               miss_next;

    assign accept       = pkt_valid && pkt_ready;
    assign capture_done = (state == CAPTURE) && ctrl_spike_buffer_wen;
    // In CAPTURE the read port looks one slot ahead for a back-to-back reload.
    assign rd_slot      = (state == CAPTURE) ? rd_ptr + DLY_W'(1) : rd_ptr;

    always_comb begin
        bypass = '0;
        if (accept && (pkt_delay == '0)) begin
            bypass[pkt_axon] = 1'b1;
        end
    end

    sched_slot_mem #(
        .N_AXONS (N_AXONS),
        .AXON_W  (AXON_W),
        .DLY_W   (DLY_W)
    ) u_slot_mem (
        .clk      (clk),
        .rst      (rst),
        .set_en   (accept),
        .set_slot (rd_ptr + pkt_delay),
        .set_axon (pkt_axon),
        .clr_en   (capture_done),
        .clr_slot (rd_ptr),
        .rd_slot  (rd_slot),
        .rd_data  (rd_data)
    );

`ifdef SCHED_PENDING_TICK_EN
    logic pending;
    logic pending_next;
    logic consume;

    // A tick that cannot start now is parked; only a second parked tick is a miss.
    always_comb begin
        consume      = pending && ((state == IDLE) || capture_done);
        pending_next = pending && !consume;
        miss_next    = 1'b0;
        if (tick && ((state != IDLE) || pending)) begin
            if (pending_next) begin
                miss_next = 1'b1;
            end else begin
                pending_next = 1'b1;
            end
        end
    end

    assign tick_go = tick || pending;
    assign reload  = pending;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= 1'b0;
        end else begin
            pending <= pending_next;
        end
    end
`else
    assign tick_go   = tick;
    assign reload    = 1'b0;
    assign miss_next = tick && (state != IDLE);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            spike_vec  <= '0;
            pkt_ready  <= 1'b1;
            ctrl_start <= 1'b0;
            tick_miss  <= 1'b0;
        end else begin
            ctrl_start <= 1'b0;
            tick_miss  <= miss_next;
            case (state)
                IDLE: begin
                    if (tick_go) begin
                        state     <= WAIT_RDY;
                        spike_vec <= rd_data | bypass;
                        pkt_ready <= 1'b0;
                    end
                end
                WAIT_RDY: begin
                    if (ctrl_ready) begin
                        state      <= START;
                        ctrl_start <= 1'b1;
                    end
                end
                START: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (ctrl_spike_buffer_wen) begin
                        rd_ptr <= rd_ptr + DLY_W'(1);
                        if (reload) begin
                            state     <= WAIT_RDY;
                            spike_vec <= rd_data;
                        end else begin
                            state     <= IDLE;
                            spike_vec <= '0;
                            pkt_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axon_spike_scheduler.md
Name: axon_spike_scheduler

Overview:
- Upstream neighbour of the core controller.
- Accepts incoming spike packets (target axon plus tick delay) on a valid/ready interface and buffers them in a circular per-tick schedule.
- On each global tick, waits for the controller to report ready, pulses its start, and presents the due slot's axon spike vector until the controller captures it into the input spike buffer.
- Clears the delivered slot and advances the tick pointer.

Parameters:
- N_AXONS, 16, axons per core; width of the spike vector.
- AXON_W, 4, axon address width, clog2(N_AXONS).
- DLY_W, 4, delay field width; N_SLOTS = 2**DLY_W schedule slots.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-low reset.
- tick  input  1  global timestep pulse, one cycle.
- pkt_valid  input  1  incoming packet valid.
- pkt_ready  output  1  scheduler can accept a packet.
- pkt_axon  input  AXON_W  target axon of the packet.
- pkt_delay  input  DLY_W  ticks of delay; 0 means delivered on the next tick.
- ctrl_ready  input  1  controller ready (idle in its WAIT state).
- ctrl_start  output  1  one-cycle start pulse to the controller.
- ctrl_spike_buffer_wen  input  1  controller strobe capturing spike_vec.
- spike_vec  output  N_AXONS  axon spikes due this tick; held while delivering.
- tick_miss  output  1  one-cycle pulse when a tick is dropped.

Behaviour:
- Reset (rst==0 at a clk edge):
  - All slots cleared, rd_ptr=0, state IDLE.
  - Outputs: pkt_ready=1, ctrl_start=0, spike_vec=0, tick_miss=0.
  - Reset mid-delivery abandons the tick; no start is reissued.
- Storage: N_SLOTS x N_AXONS bit array; rd_ptr (DLY_W bits) names the slot due on the next tick.
- Packet accept: on pkt_valid && pkt_ready, at the next edge set bit pkt_axon of slot (rd_ptr + pkt_delay) mod N_SLOTS.
  - Every delay value is legal.
  - Duplicate packets OR together (idempotent).
  - pkt_ready=1 only in IDLE.
- FSM states: IDLE, WAIT_RDY, START, CAPTURE.
  - IDLE: on tick -> WAIT_RDY; register spike_vec <= slot[rd_ptr], including a same-cycle accepted packet with delay 0 (bypass merge).
  - WAIT_RDY: hold spike_vec. If ctrl_ready -> START.
  - START: ctrl_start=1 for exactly this cycle -> CAPTURE.
  - CAPTURE: hold spike_vec until ctrl_spike_buffer_wen=1. In that same cycle: clear slot[rd_ptr], rd_ptr <= rd_ptr+1 (wraps N_SLOTS-1 -> 0), next state IDLE. spike_vec returns to 0 one cycle later.
- Tick-to-start latency: 2 cycles when ctrl_ready is already high.
- tick arriving in any state except IDLE: tick_miss pulses the next cycle; the tick is otherwise ignored (without the optional feature).
- ctrl_spike_buffer_wen outside CAPTURE is ignored.
- ctrl_ready is sampled only in WAIT_RDY.

Optional Feature:
- Macro: SCHED_PENDING_TICK_EN.
- Defined:
  - A one-deep pending-tick flag stores one tick that arrives outside IDLE; tick_miss is not pulsed for it.
  - On return to IDLE with the flag set, go directly to WAIT_RDY (flag cleared, spike_vec loaded from the new rd_ptr). pkt_ready stays 0 for that cycle.
  - A second tick while the flag is set pulses tick_miss.
- Undefined: no flag; every non-IDLE tick pulses tick_miss.

Decomposition:
- Package axon_sched_pkg: state enum sched_state_t {IDLE, WAIT_RDY, START, CAPTURE}; default N_AXONS/AXON_W/DLY_W constants.
- Sub-module sched_slot_mem holds the slot array. Interface: set port (slot, axon, en); clear port (slot, en); async read of one slot. It handles set and clear of different slots in the same cycle.

Test Plan:
- Reset, then packet (axon=5, delay=0) -> tick with ctrl_ready=1 -> ctrl_start pulses 2 cycles after tick; spike_vec=0x0020 held until ctrl_spike_buffer_wen; slot cleared; next tick delivers 0x0000.
- Packets axon=3 delay=2 and axon=3 delay=2 (duplicate) plus axon=15 delay=2 -> ticks 1 and 2 deliver 0x0000; tick 3 delivers 0x8008.
- 17 ticks with rd_ptr wrapping; a packet delay=15 issued at rd_ptr=14 -> delivered on the 16th tick after issue; rd_ptr returns to 14 at that point.
- ctrl_ready held 0 for 10 cycles after tick -> no ctrl_start, pkt_ready=0, spike_vec stable; a tick during this -> tick_miss one pulse (macro off). With the macro on: no tick_miss, and a second delivery follows immediately after capture.
- pkt_valid with delay=0 in the same cycle as tick -> spike_vec includes that axon bit.
- rst=0 during CAPTURE -> next cycle ctrl_start=0, spike_vec=0, pkt_ready=1; previously scheduled spikes are gone.
